// File: rtl/bit_serial_adder_if.sv
// Operand/result bundle for the bit-serial add/subtract unit.
//   start, sub, a, b : request side, driven by the master, sampled while idle
//   busy, done       : status, driven by the adder
//   result, cout,
//   overflow, zero   : last completed result and flags, driven by the adder
interface bit_serial_adder_if #(
    parameter int unsigned WIDTH = 8
);
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             cout;
    logic             overflow;
    logic             zero;

    modport master (
        output start, sub, a, b,
        input  busy, done, result, cout, overflow, zero
    );

    modport slave (
        input  start, sub, a, b,
        output busy, done, result, cout, overflow, zero
    );
endinterface

// File: rtl/bit_serial_adder.sv
// Bit-serial add/subtract unit: one full_adder cell evaluated once per clock, LSB first.
// Ports:
//   clk   : clock, all state changes on the rising edge
//   rst_n : asynchronous active-low reset
//   bus   : bit_serial_adder_if slave (start/sub/a/b in; busy/done/result/flags out)
// Subtraction is a + ~b + 1: b is inverted on capture and the carry flop is seeded with sub.
// Flags and result are updated only on the edge that enters the done state.

module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);
    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule

module bit_serial_adder #(
    parameter int unsigned WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    bit_serial_adder_if.slave     bus
);
    localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CntW-1:0] LastBit = CntW'(WIDTH - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e           state_q, state_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] a_sr_q, a_sr_d;
    logic [WIDTH-1:0] b_sr_q, b_sr_d;
    logic [WIDTH-1:0] sum_sr_q, sum_sr_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             zero_q, zero_d;

    logic             fa_s;
    logic             fa_cout;
    logic [WIDTH-1:0] sum_next;

    full_adder u_fa (
        .a    (a_sr_q[0]),
        .b    (b_sr_q[0]),
        .cin  (carry_q),
        .s    (fa_s),
        .cout (fa_cout)
    );

    // New sum bit enters at the MSB so after WIDTH shifts bit 0 lands in position 0.
    assign sum_next = {fa_s, sum_sr_q[WIDTH-1:1]};

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        carry_d  = carry_q;
        a_sr_d   = a_sr_q;
        b_sr_d   = b_sr_q;
        sum_sr_d = sum_sr_q;
        result_d = result_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;
        zero_d   = zero_q;

        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    a_sr_d  = bus.a;
                    b_sr_d  = bus.sub ? ~bus.b : bus.b;
                    carry_d = bus.sub;
                    cnt_d   = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                a_sr_d   = a_sr_q >> 1;
                b_sr_d   = b_sr_q >> 1;
                sum_sr_d = sum_next;
                carry_d  = fa_cout;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == LastBit) begin
                    // carry_q is the carry into the MSB on this bit.
                    result_d = sum_next;
                    cout_d   = fa_cout;
                    ovf_d    = carry_q ^ fa_cout;
                    zero_d   = (sum_next == '0);
                    cnt_d    = '0;
                    state_d  = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            carry_q  <= 1'b0;
            a_sr_q   <= '0;
            b_sr_q   <= '0;
            sum_sr_q <= '0;
            result_q <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
            zero_q   <= 1'b1;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            carry_q  <= carry_d;
            a_sr_q   <= a_sr_d;
            b_sr_q   <= b_sr_d;
            sum_sr_q <= sum_sr_d;
            result_q <= result_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
            zero_q   <= zero_d;
        end
    end

    assign bus.busy     = (state_q == StRun);
    assign bus.done     = (state_q == StDone);
    assign bus.result   = result_q;
    assign bus.cout     = cout_q;
    assign bus.overflow = ovf_q;
    assign bus.zero     = zero_q;

endmodule

// File: tb/tb_bit_serial_adder.sv
// Directed bench for bit_serial_adder at WIDTH=8: a vector table for single operations plus
// hand-written sequences for ignored starts, mid-run reset and back-to-back operation.
module tb_bit_serial_adder;
    localparam int unsigned W = 8;

    logic clk;
    logic rst_n;

    bit_serial_adder_if #(.WIDTH(W)) bus ();

    bit_serial_adder #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       sub;
        logic [7:0] res;
        logic       c;
        logic       v;
        logic       z;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Issue one operation; returns edges from the sampling edge to done and busy-sample count.
    // Leaves the block back in idle.
    task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic s,
                         output int lat, output int busy_cnt);
        @(negedge clk);
        bus.a = a;
        bus.b = b;
        bus.sub = s;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        lat = 0;
        busy_cnt = bus.busy ? 1 : 0;
        while (lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
            if (bus.done) break;
            if (bus.busy) busy_cnt++;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        int lat, bcnt, done_cnt, hold_bad, last_done, interval_bad;
        logic [7:0] prev_res;

        vecs[0] = '{8'h3C, 8'h0F, 1'b0, 8'h4B, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1};
        vecs[2] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{8'h05, 8'h07, 1'b1, 8'hFE, 1'b0, 1'b0, 1'b0};
        vecs[4] = '{8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1, 1'b0};
        vecs[5] = '{8'h10, 8'h10, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1};
        vecs[6] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1};

        rst_n = 1'b0;
        bus.start = 1'b0;
        bus.sub = 1'b0;
        bus.a = '0;
        bus.b = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_result", bus.result, 0);
        check("rst_cout", bus.cout, 0);
        check("rst_ovf", bus.overflow, 0);
        check("rst_zero", bus.zero, 1);
        rst_n = 1'b1;

        for (int i = 0; i < 7; i++) begin
            do_op(vecs[i].a, vecs[i].b, vecs[i].sub, lat, bcnt);
            check($sformatf("v%0d_latency", i), lat, 8);
            check($sformatf("v%0d_busy_cycles", i), bcnt, 8);
            check($sformatf("v%0d_result", i), bus.result, vecs[i].res);
            check($sformatf("v%0d_cout", i), bus.cout, vecs[i].c);
            check($sformatf("v%0d_ovf", i), bus.overflow, vecs[i].v);
            check($sformatf("v%0d_zero", i), bus.zero, vecs[i].z);
            check($sformatf("v%0d_done_cleared", i), bus.done, 0);
        end

        // Start 0x10+0x20, then retry start and wiggle operands while it runs.
        prev_res = bus.result;
        @(negedge clk);
        bus.a = 8'h10;
        bus.b = 8'h20;
        bus.sub = 1'b0;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        done_cnt = 0;
        hold_bad = 0;
        for (int k = 1; k <= 13; k++) begin
            @(negedge clk);
            if (k <= 3) begin
                bus.start = 1'b1;
                bus.a = 8'hAA;
                bus.b = 8'h55;
                bus.sub = 1'b1;
            end else begin
                bus.start = 1'b0;
            end
            @(posedge clk);
            #1;
            if (bus.busy && bus.result !== prev_res) hold_bad++;
            if (bus.done) begin
                done_cnt++;
                check("midrun_result", bus.result, 8'h30);
                check("midrun_latency", k, 8);
            end
        end
        check("midrun_done_count", done_cnt, 1);
        check("midrun_result_held", hold_bad, 0);
        check("midrun_idle_after", bus.busy, 0);

        // start held high: a new operation every WIDTH+2 cycles.
        @(negedge clk);
        bus.a = 8'h01;
        bus.b = 8'h02;
        bus.sub = 1'b0;
        bus.start = 1'b1;
        done_cnt = 0;
        last_done = -1;
        interval_bad = 0;
        for (int k = 1; k <= 45; k++) begin
            @(posedge clk);
            #1;
            if (bus.done) begin
                done_cnt++;
                check("held_result", bus.result, 8'h03);
                if (last_done >= 0 && (k - last_done) != 10) interval_bad++;
                last_done = k;
            end
        end
        check("held_done_count", done_cnt, 4);
        check("held_interval", interval_bad, 0);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        check("held_idle_after", bus.busy, 0);

        // Async reset three cycles into 0x12+0x34.
        @(negedge clk);
        bus.a = 8'h12;
        bus.b = 8'h34;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check("pre_rst_busy", bus.busy, 1);
        rst_n = 1'b0;
        #1;
        check("arst_busy", bus.busy, 0);
        check("arst_done", bus.done, 0);
        check("arst_result", bus.result, 0);
        check("arst_zero", bus.zero, 1);
        check("arst_cout", bus.cout, 0);
        check("arst_ovf", bus.overflow, 0);
        done_cnt = 0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk);
            #1;
            if (bus.done) done_cnt++;
            if (k == 2) rst_n = 1'b1;
        end
        check("arst_no_done", done_cnt, 0);
        do_op(8'h01, 8'h01, 1'b0, lat, bcnt);
        check("post_rst_latency", lat, 8);
        check("post_rst_result", bus.result, 8'h02);
        check("post_rst_zero", bus.zero, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/bit_serial_adder.md
Name: bit_serial_adder

Overview:
- Bit-serial add/subtract unit that drives one instance of the team's single-bit full_adder cell (ports a, b, cin, s, cout), one bit per clock, LSB first.
- Registers the carry between bits and assembles the sum in a shift register.
- Sits directly upstream of the full_adder: it latches the operands, sequences bits into the adder and consumes its s/cout.
- Serves as the area-minimal ALU option for the SAP-U datapath; produces result plus carry, overflow and zero flags for the flags register.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 2..32.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst_n  input  1  asynchronous active-low reset; assertion clears all state immediately, release is synchronous to clk.
- start  input  1  request to begin an operation; sampled only in IDLE.
- sub  input  1  0 = a+b, 1 = a-b; sampled with start.
- a  input  WIDTH  operand A; sampled with start.
- b  input  WIDTH  operand B; sampled with start.
- busy  output  1  high while an operation is in progress (RUN state).
- done  output  1  one-cycle pulse when result and flags are updated.
- result  output  WIDTH  last completed sum/difference; held until next completion.
- cout  output  1  carry out of MSB; for sub, 1 = no borrow.
- overflow  output  1  signed overflow = carry into MSB XOR carry out of MSB.
- zero  output  1  result == 0.

Behaviour:
- Reset values: busy=0, done=0, result=0, cout=0, overflow=0, zero=1. State=IDLE, bit counter=0, carry flop=0, shift registers=0.
- States: IDLE, RUN, DONE.
- IDLE, start=1 at edge N:
  - Latch a into A shift register.
  - Latch b into B shift register; if sub=1, latch ~b.
  - Carry flop = sub.
  - Counter = 0; go to RUN; busy=1 from edge N.
- IDLE, start=0: stay in IDLE; all outputs hold.
- RUN, each edge:
  - Full adder inputs: a=A[0], b=B[0], cin=carry flop.
  - Sum bit shifts into the MSB of the sum shift register (right shift). A and B shift right.
  - Carry flop = adder cout. Counter increments.
  - On the bit where counter == WIDTH-1, also capture the adder's cin (carry into MSB) for overflow.
  - After that edge (edge N+WIDTH), go to DONE.
- Entry to DONE (edge N+WIDTH):
  - result = assembled sum; cout = final carry; overflow = carry_into_msb XOR final carry; zero = (sum == 0).
  - busy=0, done=1 for exactly that cycle.
- DONE: unconditionally go to IDLE on the next edge; done returns to 0.
- Latency: done is high in the cycle that begins WIDTH edges after the edge that sampled start. Minimum start-to-start spacing is WIDTH+2 cycles.
- start while in RUN or DONE: ignored, not queued. The operation in flight is unaffected.
- a, b, sub changes during RUN: no effect on the operation in flight.
- result and flag outputs do not change during RUN; they show the previous operation until the DONE update.
- Arithmetic is modulo 2^WIDTH; no saturation.
- Async reset mid-RUN: operation aborted, no done pulse, all outputs return to reset values immediately. After release, the block is in IDLE and accepts start on the first edge.
- start held high continuously: a new operation starts on every IDLE visit, i.e. every WIDTH+2 cycles.

Test Plan (WIDTH=8):
- Reset, then a=0x3C, b=0x0F, sub=0, start pulse -> done exactly 8 cycles after the sampling edge; result=0x4B, cout=0, overflow=0, zero=0; busy high for 8 cycles.
- a=0xFF, b=0x01, sub=0 -> result=0x00, cout=1, overflow=0, zero=1.
- a=0x7F, b=0x01, sub=0 -> result=0x80, cout=0, overflow=1; then a=0x05, b=0x07, sub=1 -> result=0xFE, cout=0 (borrow), overflow=0.
- Start op 0x10+0x20, then pulse start with a=0xAA and also change a/b mid-RUN -> single done; result=0x30; second start ignored; result/flags unchanged until done.
- Assert rst_n low 3 cycles into RUN of 0x12+0x34 -> busy=0, done never pulses, result=0, zero=1 immediately. After release, 0x01+0x01 -> result=0x02 after 8 cycles.
- start held high with a=0x01, b=0x02 -> done pulses repeat every 10 cycles, result=0x03 each time.
